// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared mode encoding, side indices and mode-to-side-set decode
package router_pkg;

  localparam int unsigned NUM_SIDES = 4;

  typedef logic [1:0] side_t;
  typedef logic [NUM_SIDES-1:0] side_mask_t;

  localparam side_t N = 2'd0;
  localparam side_t S = 2'd1;
  localparam side_t W = 2'd2;
  localparam side_t E = 2'd3;

  typedef enum logic [3:0] {
    ALL       = 4'd0,
    NORTH     = 4'd1,
    SOUTH     = 4'd2,
    WEST      = 4'd3,
    EAST      = 4'd4,
    EASTNORTH = 4'd5,
    EASTSOUTH = 4'd6,
    EASTWEST  = 4'd7,
    WESTNORTH = 4'd8,
    WESTSOUTH = 4'd9,
    WESTEAST  = 4'd10
  } router_mode_e;

  // Codes 11-15 fall through to the empty set.
  function automatic side_mask_t mode_to_mask(input logic [3:0] mode);
    side_mask_t m;
    m = '0;
    case (router_mode_e'(mode))
      ALL:       m = '1;
      NORTH:     m[N] = 1'b1;
      SOUTH:     m[S] = 1'b1;
      WEST:      m[W] = 1'b1;
      EAST:      m[E] = 1'b1;
      EASTNORTH: begin m[E] = 1'b1; m[N] = 1'b1; end
      EASTSOUTH: begin m[E] = 1'b1; m[S] = 1'b1; end
      EASTWEST:  begin m[E] = 1'b1; m[W] = 1'b1; end
      WESTNORTH: begin m[W] = 1'b1; m[N] = 1'b1; end
      WESTSOUTH: begin m[W] = 1'b1; m[S] = 1'b1; end
      WESTEAST:  begin m[W] = 1'b1; m[E] = 1'b1; end
      default:   m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/router_out_reg.sv
// rtl/router_out_reg.sv - one output side: data plus valid flop with async active-low clear
module router_out_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  enable_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  enable_o
);

  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  enable_d, enable_q;

  assign data_d   = data_i;
  assign enable_d = enable_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      enable_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      enable_q <= enable_d;
    end
  end

  assign data_o   = data_q;
  assign enable_o = enable_q;

endmodule

// File: rtl/router.sv
// rtl/router.sv - 4-side flit router: priority source select, mode mask decode, registered outputs
module router
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            router_mode,
  input  logic [DATA_WIDTH-1:0] north_data_i,
  input  logic [DATA_WIDTH-1:0] south_data_i,
  input  logic [DATA_WIDTH-1:0] west_data_i,
  input  logic [DATA_WIDTH-1:0] east_data_i,
  input  logic                  north_enable_i,
  input  logic                  south_enable_i,
  input  logic                  west_enable_i,
  input  logic                  east_enable_i,
  output logic [DATA_WIDTH-1:0] north_data_o,
  output logic [DATA_WIDTH-1:0] south_data_o,
  output logic [DATA_WIDTH-1:0] west_data_o,
  output logic [DATA_WIDTH-1:0] east_data_o,
  output logic                  north_enable_o,
  output logic                  south_enable_o,
  output logic                  west_enable_o,
  output logic                  east_enable_o
);

  logic [DATA_WIDTH-1:0] src_data;
  side_mask_t            src_onehot;
  side_mask_t            out_mask;

  // Fixed priority north > south > west > east; losers are dropped.
  always_comb begin
    src_data   = '0;
    src_onehot = '0;
    if (north_enable_i) begin
      src_data      = north_data_i;
      src_onehot[N] = 1'b1;
    end else if (south_enable_i) begin
      src_data      = south_data_i;
      src_onehot[S] = 1'b1;
    end else if (west_enable_i) begin
      src_data      = west_data_i;
      src_onehot[W] = 1'b1;
    end else if (east_enable_i) begin
      src_data      = east_data_i;
      src_onehot[E] = 1'b1;
    end
  end

  // No source means no outputs; the source side never echoes its own flit.
  assign out_mask = (src_onehot == '0) ? '0 : (mode_to_mask(router_mode) & ~src_onehot);

  logic [DATA_WIDTH-1:0] out_data [NUM_SIDES];
  logic                  out_en   [NUM_SIDES];

  for (genvar i = 0; i < NUM_SIDES; i++) begin : g_side
    router_out_reg #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_i   (out_mask[i] ? src_data : '0),
      .enable_i (out_mask[i]),
      .data_o   (out_data[i]),
      .enable_o (out_en[i])
    );
  end

  assign north_data_o   = out_data[N];
  assign south_data_o   = out_data[S];
  assign west_data_o    = out_data[W];
  assign east_data_o    = out_data[E];
  assign north_enable_o = out_en[N];
  assign south_enable_o = out_en[S];
  assign west_enable_o  = out_en[W];
  assign east_enable_o  = out_en[E];

endmodule

// File: tb/tb_router.sv
// tb/tb_router.sv - vector table with scoreboard plus reset and two-router chain sequences
module tb_router;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]    cw_mode, ce_mode;
  logic          chain;
  logic [DW-1:0] d_in [4];
  logic [3:0]    en_in;

  logic [DW-1:0] cw_d_o [4];
  logic          cw_en_o [4];
  logic [DW-1:0] ce_d_o [4];
  logic          ce_en_o [4];

  logic [DW-1:0] cw_e_d;
  logic          cw_e_en;
  assign cw_e_d  = chain ? ce_d_o[2]  : d_in[3];
  assign cw_e_en = chain ? ce_en_o[2] : en_in[3];

  router #(.DATA_WIDTH(DW)) u_cw (
    .clk(clk), .rst_n(rst_n), .router_mode(cw_mode),
    .north_data_i(d_in[0]), .south_data_i(d_in[1]), .west_data_i(d_in[2]), .east_data_i(cw_e_d),
    .north_enable_i(en_in[0]), .south_enable_i(en_in[1]), .west_enable_i(en_in[2]), .east_enable_i(cw_e_en),
    .north_data_o(cw_d_o[0]), .south_data_o(cw_d_o[1]), .west_data_o(cw_d_o[2]), .east_data_o(cw_d_o[3]),
    .north_enable_o(cw_en_o[0]), .south_enable_o(cw_en_o[1]), .west_enable_o(cw_en_o[2]), .east_enable_o(cw_en_o[3])
  );

  router #(.DATA_WIDTH(DW)) u_ce (
    .clk(clk), .rst_n(rst_n), .router_mode(ce_mode),
    .north_data_i(16'h0), .south_data_i(16'h0), .west_data_i(cw_d_o[3]), .east_data_i(16'h0),
    .north_enable_i(1'b0), .south_enable_i(1'b0), .west_enable_i(cw_en_o[3]), .east_enable_i(1'b0),
    .north_data_o(ce_d_o[0]), .south_data_o(ce_d_o[1]), .west_data_o(ce_d_o[2]), .east_data_o(ce_d_o[3]),
    .north_enable_o(ce_en_o[0]), .south_enable_o(ce_en_o[1]), .west_enable_o(ce_en_o[2]), .east_enable_o(ce_en_o[3])
  );

  typedef struct {
    logic [3:0]    mode;
    logic [3:0]    en;
    logic [DW-1:0] dn, ds, dw, de;
    logic [3:0]    exp_mask;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    int            row;
    logic [3:0]    mask;
    logic [DW-1:0] data;
  } exp_t;

  vec_t vecs [16];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bit order of mask: [0]=north [1]=south [2]=west [3]=east.
  task automatic check_cw(input string name, input logic [3:0] mask, input logic [DW-1:0] data);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s.en%0d", name, i), {31'd0, cw_en_o[i]}, {31'd0, mask[i]});
      check($sformatf("%s.data%0d", name, i), {16'd0, cw_d_o[i]}, {16'd0, (mask[i] ? data : 16'h0)});
    end
  endtask

  task automatic drive(input logic [3:0] mode, input logic [3:0] en,
                       input logic [DW-1:0] dn, input logic [DW-1:0] ds,
                       input logic [DW-1:0] dw, input logic [DW-1:0] de);
    cw_mode = mode;
    en_in   = en;
    d_in[0] = dn; d_in[1] = ds; d_in[2] = dw; d_in[3] = de;
  endtask

  initial begin
    //           mode   en       dn       ds       dw       de       mask     data
    vecs[0]  = '{4'd6,  4'b0001, 16'h0005, 16'h0101, 16'h0202, 16'h0303, 4'b1010, 16'h0005};
    vecs[1]  = '{4'd0,  4'b0100, 16'h0101, 16'h0202, 16'h00AA, 16'h0303, 4'b1011, 16'h00AA};
    vecs[2]  = '{4'd3,  4'b1001, 16'h1111, 16'h0202, 16'h0303, 16'h2222, 4'b0100, 16'h1111};
    vecs[3]  = '{4'd12, 4'b1111, 16'h1234, 16'h2345, 16'h3456, 16'h4567, 4'b0000, 16'h0000};
    vecs[4]  = '{4'd1,  4'b0001, 16'h9999, 16'h0202, 16'h0303, 16'h0404, 4'b0000, 16'h0000};
    vecs[5]  = '{4'd0,  4'b0001, 16'hABCD, 16'h0202, 16'h0303, 16'h0404, 4'b1110, 16'hABCD};
    vecs[6]  = '{4'd0,  4'b1000, 16'h0101, 16'h0202, 16'h0303, 16'h0E0E, 4'b0111, 16'h0E0E};
    vecs[7]  = '{4'd7,  4'b1110, 16'h0101, 16'h3333, 16'h0303, 16'h0404, 4'b1100, 16'h3333};
    vecs[8]  = '{4'd10, 4'b1100, 16'h0101, 16'h0202, 16'h4444, 16'h0404, 4'b1000, 16'h4444};
    vecs[9]  = '{4'd8,  4'b1000, 16'h0101, 16'h0202, 16'h0303, 16'h5555, 4'b0101, 16'h5555};
    vecs[10] = '{4'd9,  4'b0000, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 4'b0000, 16'h0000};
    vecs[11] = '{4'd5,  4'b0010, 16'h0101, 16'hFFFF, 16'h0303, 16'h0404, 4'b1001, 16'hFFFF};
    vecs[12] = '{4'd4,  4'b1000, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 4'b0000, 16'h0000};
    vecs[13] = '{4'd2,  4'b1100, 16'h0101, 16'h0202, 16'h0101, 16'h0404, 4'b0010, 16'h0101};
    vecs[14] = '{4'd15, 4'b0001, 16'h7E7E, 16'h0202, 16'h0303, 16'h0404, 4'b0000, 16'h0000};
    vecs[15] = '{4'd0,  4'b0000, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 4'b0000, 16'h0000};

    chain   = 1'b0;
    ce_mode = 4'd12;
    rst_n   = 1'b0;
    drive(4'd0, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);

    repeat (2) @(negedge clk);
    check_cw("reset_hold", 4'b0000, 16'h0);
    drive(4'd0, 4'b0001, 16'hDEAD, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    check_cw("reset_ignores_input", 4'b0000, 16'h0);

    drive(4'd0, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_cw("post_reset_idle", 4'b0000, 16'h0);

    // Back-to-back flits, one per cycle, each checked one cycle after it is driven.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].mode, vecs[i].en, vecs[i].dn, vecs[i].ds, vecs[i].dw, vecs[i].de);
      sb.push_back('{row: i, mask: vecs[i].exp_mask, data: vecs[i].exp_data});
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_cw($sformatf("vec%0d", e.row), e.mask, e.data);
      end
    end

    // Asynchronous clear of a registered flit, then first flit after release.
    drive(4'd0, 4'b0001, 16'hBEEF, 16'h0, 16'h0, 16'h0);
    @(posedge clk); #2;
    check_cw("pre_async", 4'b1110, 16'hBEEF);
    rst_n = 1'b0;
    #1;
    check_cw("async_clear", 4'b0000, 16'h0);
    @(posedge clk); #1;
    check_cw("held_in_reset", 4'b0000, 16'h0);
    @(negedge clk);
    drive(4'd3, 4'b0010, 16'h0, 16'h7777, 16'h0, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_cw("first_after_reset", 4'b0100, 16'h7777);

    // Two-router chain: west router EASTSOUTH, east router NORTH.
    drive(4'd12, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chain   = 1'b1;
    ce_mode = 4'd1;
    drive(4'd6, 4'b0001, 16'h0032, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    check("chain_cw_south_data", {16'd0, cw_d_o[1]}, 32'h0032);
    check("chain_cw_south_en", {31'd0, cw_en_o[1]}, 32'd1);
    check("chain_ce_north_early", {31'd0, ce_en_o[0]}, 32'd0);
    drive(4'd6, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    check("chain_ce_north_data", {16'd0, ce_d_o[0]}, 32'h0032);
    check("chain_ce_north_en", {31'd0, ce_en_o[0]}, 32'd1);
    check("chain_ce_west_en", {31'd0, ce_en_o[2]}, 32'd0);
    check("chain_cw_south_idle", {31'd0, cw_en_o[1]}, 32'd0);
    @(negedge clk);
    check("chain_ce_north_done", {31'd0, ce_en_o[0]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router.md
ROUTER -- requirements
Module: router

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the width of every data port.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port router_mode, input, 4 bits: output-direction select (encoding in REQ-010).
REQ-005 The block SHALL have ports north_data_i, south_data_i, west_data_i, east_data_i, each input, DATA_WIDTH bits: incoming flit per side.
REQ-006 The block SHALL have ports north_enable_i, south_enable_i, west_enable_i, east_enable_i, each input, 1 bit: incoming flit valid per side.
REQ-007 The block SHALL have ports north_data_o, south_data_o, west_data_o, east_data_o, each output, DATA_WIDTH bits: outgoing flit per side.
REQ-008 The block SHALL have ports north_enable_o, south_enable_o, west_enable_o, east_enable_o, each output, 1 bit: outgoing flit valid per side.
REQ-009 There SHALL be no backpressure or ready signal, so every accepted flit is forwarded unconditionally.

Function
REQ-010 router_mode SHALL select the output set as follows:
- 0 ALL
- 1 N
- 2 S
- 3 W
- 4 E
- 5 E+N
- 6 E+S
- 7 E+W
- 8 W+N
- 9 W+S
- 10 W+E (same as 7)
- 11-15: empty set.
REQ-011 Source selection SHALL be fixed priority among asserted enable_i: north > south > west > east.
REQ-012 If no enable_i is asserted, every enable_o SHALL be 0 on the next cycle.
REQ-013 Mode ALL SHALL mean all four sides except the selected source side.
REQ-014 A side that is both in the explicit mode set and the selected source SHALL be suppressed; there is no U-turn.
REQ-015 Non-selected inputs SHALL be dropped silently.
REQ-016 Each side in the resulting output set SHALL present the source data_i on data_o with enable_o=1, registered: 1 clock of latency from sampled inputs to outputs.
REQ-017 Sides not in the output set SHALL drive enable_o=0 and data_o=0 on that cycle.
REQ-018 router_mode and all inputs SHALL be sampled together each cycle, and a mode change SHALL take effect for the flit sampled on the same edge.
REQ-019 Multicast SHALL be duplication: every selected output carries an identical data value in the same cycle.
REQ-020 Two routers chained side to side (west_0.east_data_o to east_0.west_data_i, and back) SHALL give 2 cycles end-to-end latency.
REQ-021 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-022 While rst_n=0, all data_o SHALL be 0 and all enable_o SHALL be 0, asynchronously.
REQ-023 The first forwarded flit SHALL be the one sampled on the first rising clk edge after rst_n deasserts.
REQ-024 A flit in flight when rst_n asserts SHALL be discarded.
REQ-025 The block SHALL hold no other state.

Structure
REQ-026 Package router_pkg SHALL hold the mode enum (ALL..WESTEAST, 4-bit) and the side-index constants N=0, S=1, W=2, E=3.
REQ-027 The module SHALL be one source-select plus output-mask decode stage followed by per-side output registers.
REQ-028 Sub-module router_out_reg (DATA_WIDTH data plus enable flop with async active-low clear) SHALL be instantiated four times.

Verification
REQ-029 Scenario: reset -> all enable_o=0 and all data_o=0 during and after reset with all enable_i=0.
REQ-030 Scenario: mode=6 (EASTSOUTH), north_enable_i=1, north_data_i=0x0005 -> next cycle east_data_o=south_data_o=0x0005, east_enable_o=south_enable_o=1, north_enable_o=west_enable_o=0.
REQ-031 Scenario: two-router chain, west router mode=6 and east router mode=1 (NORTH), north_data_i of west router=0x0032 -> 2 cycles later east router north_data_o=0x0032 with north_enable_o=1, and west router south_data_o=0x0032 after 1 cycle.
REQ-032 Scenario: mode=0 (ALL), west_enable_i=1, west_data_i=0x00AA -> next cycle north, south and east carry 0x00AA with enable_o=1, and west_enable_o=0.
REQ-033 Scenario: north_enable_i=1 (0x1111) and east_enable_i=1 (0x2222) simultaneously, mode=3 (WEST) -> next cycle west_data_o=0x1111 because north wins.
REQ-034 Scenario: mode=12 with any input valid -> every enable_o=0; then rst_n pulses low mid-stream -> outputs clear immediately without waiting for clk.
